// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control
// ----------------------------------------------------------------------------
// Multi-cycle control unit for an RV32I core. Each instruction is sequenced
// through FETCH, DECODE, EXEC, MEM and WB, handshaking with a shared
// instruction/data memory. Illegal opcodes/funct3 values and memory requests
// that wait too long both trap into a sticky TRAP state that only reset
// leaves. A retired-instruction counter advances on every PC update.
//
// Parameters:
//   TIMEOUT   max consecutive memory wait cycles before trapping (0 = off)
//   CNT_W     width of the retired-instruction counter
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   opcode     in   instruction register [6:0], valid from DECODE onward
//   funct3     in   instruction register [14:12]
//   zero       in   ALU zero flag, used by branches in EXEC
//   mem_ready  in   memory completes the current request this cycle
//   mem_req    out  memory request (FETCH, MEM)
//   ir_wr      out  latch the instruction register
//   pc_wr      out  update the PC (one pulse per retired instruction)
//   PCSrc      out  00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared
//   ALUSrcA    out  0 rs1, 1 constant zero
//   ALUSrc     out  0 rs2, 1 immediate
//   ALUOp      out  00 add, 01 sub, 10 R-type decode, 11 I-type decode
//   RegWr      out  register file write
//   MemWr      out  memory write
//   MemRead    out  memory read
//   MemtoReg   out  write-back select: 00 ALU, 01 mem, 10 PC+4, 11 PC+imm
//   fault      out  high while in TRAP
//   illegal    out  sticky: trap cause was a bad opcode or funct3
//   state      out  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
//   instret    out  retired-instruction count, wraps
// ============================================================================
module multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic             ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             RegWr,
    output logic             MemWr,
    output logic             MemRead,
    output logic [1:0]       MemtoReg,
    output logic             fault,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // A zero TIMEOUT still needs a one-bit counter to keep the logic legal.
    localparam int                WAIT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit                TO_EN     = (TIMEOUT > 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             state_r;
    state_t             state_nxt_s;
    logic               illegal_r;
    logic               set_illegal_s;
    logic [WAIT_W-1:0]  wait_r;
    logic [CNT_W-1:0]   instret_r;

    logic               legal_s;
    logic               is_load_s;
    logic               is_store_s;
    logic               is_branch_s;
    logic               taken_s;
    logic               timeout_s;
    logic [1:0]         alu_op_s;
    logic               alu_src_s;
    logic               alu_srca_s;

    assign is_load_s   = (opcode == OP_LOAD);
    assign is_store_s  = (opcode == OP_STORE);
    assign is_branch_s = (opcode == OP_BRANCH);
    // Only BEQ (000) and BNE (001) ever reach EXEC.
    assign taken_s     = (funct3 == 3'b000) ? zero : ~zero;

    // The threshold cycle is the one whose wait would make the count reach
    // TIMEOUT; a mem_ready in that same cycle still completes normally.
    assign timeout_s   = TO_EN && mem_req && !mem_ready && (wait_r >= WAIT_LAST);

    // Opcode legality check used in DECODE.
    always_comb begin
        legal_s = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_s = 1'b1;
            OP_BRANCH: legal_s = (funct3 == 3'b000) || (funct3 == 3'b001);
            default:   legal_s = 1'b0;
        endcase
    end

    // ALU operand/operation selects for EXEC, reused in WB to hold the result.
    always_comb begin
        alu_op_s   = 2'b00;
        alu_src_s  = 1'b0;
        alu_srca_s = 1'b0;
        case (opcode)
            OP_R: begin
                alu_op_s  = 2'b10;
                alu_src_s = 1'b0;
            end
            OP_I: begin
                alu_op_s  = 2'b11;
                alu_src_s = 1'b1;
            end
            OP_LOAD, OP_STORE, OP_JALR: begin
                alu_op_s  = 2'b00;
                alu_src_s = 1'b1;
            end
            OP_LUI: begin
                alu_op_s   = 2'b00;
                alu_src_s  = 1'b1;
                alu_srca_s = 1'b1;
            end
            OP_BRANCH: begin
                alu_op_s  = 2'b01;
                alu_src_s = 1'b0;
            end
            default: begin
                alu_op_s   = 2'b00;
                alu_src_s  = 1'b0;
                alu_srca_s = 1'b0;
            end
        endcase
    end

    // Next-state and strobe decode; reset forces every strobe low.
    always_comb begin
        state_nxt_s   = state_r;
        set_illegal_s = 1'b0;
        mem_req       = 1'b0;
        ir_wr         = 1'b0;
        pc_wr         = 1'b0;
        PCSrc         = 2'b00;
        ALUSrcA       = 1'b0;
        ALUSrc        = 1'b0;
        ALUOp         = 2'b00;
        RegWr         = 1'b0;
        MemWr         = 1'b0;
        MemRead       = 1'b0;
        MemtoReg      = 2'b00;
        if (rst) begin
            state_nxt_s = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        ir_wr       = 1'b1;
                        state_nxt_s = S_DECODE;
                    end else if (timeout_s) begin
                        state_nxt_s = S_TRAP;
                    end else begin
                        state_nxt_s = S_FETCH;
                    end
                end
                S_DECODE: begin
                    if (legal_s) begin
                        state_nxt_s = S_EXEC;
                    end else begin
                        state_nxt_s   = S_TRAP;
                        set_illegal_s = 1'b1;
                    end
                end
                S_EXEC: begin
                    ALUOp   = alu_op_s;
                    ALUSrc  = alu_src_s;
                    ALUSrcA = alu_srca_s;
                    if (is_branch_s) begin
                        pc_wr       = 1'b1;
                        PCSrc       = taken_s ? 2'b01 : 2'b00;
                        state_nxt_s = S_FETCH;
                    end else if (is_load_s || is_store_s) begin
                        state_nxt_s = S_MEM;
                    end else begin
                        state_nxt_s = S_WB;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    ALUOp   = 2'b00;
                    ALUSrc  = 1'b1;
                    MemRead = is_load_s;
                    MemWr   = is_store_s;
                    if (mem_ready) begin
                        if (is_store_s) begin
                            pc_wr       = 1'b1;
                            PCSrc       = 2'b00;
                            state_nxt_s = S_FETCH;
                        end else begin
                            state_nxt_s = S_WB;
                        end
                    end else if (timeout_s) begin
                        state_nxt_s = S_TRAP;
                    end else begin
                        state_nxt_s = S_MEM;
                    end
                end
                S_WB: begin
                    RegWr       = 1'b1;
                    pc_wr       = 1'b1;
                    ALUOp       = alu_op_s;
                    ALUSrc      = alu_src_s;
                    ALUSrcA     = alu_srca_s;
                    state_nxt_s = S_FETCH;
                    case (opcode)
                        OP_LOAD: begin
                            MemtoReg = 2'b01;
                            PCSrc    = 2'b00;
                        end
                        OP_JAL: begin
                            MemtoReg = 2'b10;
                            PCSrc    = 2'b01;
                        end
                        OP_JALR: begin
                            MemtoReg = 2'b10;
                            PCSrc    = 2'b10;
                        end
                        OP_AUIPC: begin
                            MemtoReg = 2'b11;
                            PCSrc    = 2'b00;
                        end
                        default: begin
                            MemtoReg = 2'b00;
                            PCSrc    = 2'b00;
                        end
                    endcase
                end
                S_TRAP: begin
                    state_nxt_s = S_TRAP;
                end
                default: begin
                    // Unreachable encodings are treated as a fault.
                    state_nxt_s = S_TRAP;
                end
            endcase
        end
    end

    // State, sticky illegal flag, memory wait counter and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_FETCH;
            illegal_r <= 1'b0;
            wait_r    <= {WAIT_W{1'b0}};
            instret_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (set_illegal_s) begin
                illegal_r <= 1'b1;
            end else begin
                illegal_r <= illegal_r;
            end
            // Count only while the same request keeps waiting; any completion
            // or state change starts the next request from zero.
            if (mem_req && !mem_ready && (state_nxt_s == state_r)) begin
                wait_r <= wait_r + {{(WAIT_W-1){1'b0}}, 1'b1};
            end else begin
                wait_r <= {WAIT_W{1'b0}};
            end
            if (pc_wr) begin
                instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                instret_r <= instret_r;
            end
        end
    end

    assign fault   = (state_r == S_TRAP);
    assign illegal = illegal_r;
    assign state   = state_r;
    assign instret = instret_r;

endmodule

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control
// ----------------------------------------------------------------------------
// Self-checking bench for multicycle_control (TIMEOUT=4, CNT_W=2). A reactive
// memory answers each request after a chosen number of wait cycles; a model
// derives latency, strobe counts, trap outcome and instret from the
// instruction class and the wait counts.
// ============================================================================
module tb_multicycle_control;

    localparam int TO = 4;
    localparam int CW = 2;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;
    localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_BAD = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          zero;
    logic          mem_ready;
    logic          mem_req, ir_wr, pc_wr, ALUSrcA, ALUSrc, RegWr, MemWr, MemRead;
    logic [1:0]    PCSrc, ALUOp, MemtoReg;
    logic          fault, illegal;
    logic [2:0]    state;
    logic [CW-1:0] instret;

    int n_pass  = 0;
    int n_total = 0;
    int exp_ret = 0;
    int st_trace[64];
    int trace_len;
    logic [6:0] legal_ops[9];

    multicycle_control #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .ir_wr(ir_wr), .pc_wr(pc_wr),
        .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .RegWr(RegWr), .MemWr(MemWr), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .fault(fault), .illegal(illegal), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int kind_of(input logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            default:    return K_BAD;
        endcase
    endfunction

    function automatic logic [13:0] strobes();
        return {mem_req, ir_wr, pc_wr, RegWr, MemWr, MemRead, PCSrc,
                ALUSrcA, ALUSrc, ALUOp, MemtoReg};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rst_strobes", 32'(strobes()), 32'd0);
        @(posedge clk); #1;
        chk("rst_strobes_edge", 32'(strobes()), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst = 1'b0;
        mem_ready = 1'b0;
        exp_ret = 0;
        #1;
        chk("rst_fault", 32'(fault), 32'd0);
    endtask

    // Runs one instruction from FETCH; fw/mw are wait cycles before the
    // fetch and data requests complete; hold = cycles observed in TRAP.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int fw, input int mw, input int hold);
        int  k;
        bit  ldst, bad, regk;
        int  e_trap, e_ill, e_cyc, e_irwr, e_regwr, e_memwr, e_memrd, e_pcsrc, e_m2r;
        int  cyc, req_idx, waited, done, trapped, retired;
        int  regwr_cnt, memwr_cnt, memrd_cnt, irwr_cnt, pcwr_cnt, overlap;
        int  pcsrc_at, m2r_at, regwr_at;
        logic req_s, rdy_s;

        k    = kind_of(op);
        ldst = (k == K_LD) || (k == K_ST);
        bad  = (k == K_BAD) || ((k == K_BR) && (f3 > 3'd1));
        regk = (k == K_R) || (k == K_I) || (k == K_LD) || (k == K_JAL) ||
               (k == K_JALR) || (k == K_LUI) || (k == K_AUIPC);
        e_trap = 1; e_ill = 0; e_irwr = 1;
        if (fw >= TO) begin
            e_cyc = TO; e_irwr = 0;
        end else if (bad) begin
            e_cyc = fw + 2; e_ill = 1;
        end else if (ldst && mw >= TO) begin
            e_cyc = fw + 3 + TO;
        end else begin
            e_trap = 0;
            e_cyc  = fw + ((k == K_BR) ? 3 : (k == K_LD) ? 5 : 4) + (ldst ? mw : 0);
        end
        e_regwr = (!e_trap && regk) ? 1 : 0;
        e_memwr = (k == K_ST && fw < TO) ? ((mw >= TO) ? TO : mw + 1) : 0;
        e_memrd = ((fw >= TO) ? TO : fw + 1) +
                  ((k == K_LD && fw < TO) ? ((mw >= TO) ? TO : mw + 1) : 0);
        case (k)
            K_BR:    e_pcsrc = (((f3 == 3'd0) ? z : !z) ? 1 : 0);
            K_JAL:   e_pcsrc = 1;
            K_JALR:  e_pcsrc = 2;
            default: e_pcsrc = 0;
        endcase
        case (k)
            K_LD:         e_m2r = 1;
            K_JAL, K_JALR: e_m2r = 2;
            K_AUIPC:      e_m2r = 3;
            default:      e_m2r = 0;
        endcase

        opcode = op; funct3 = f3; zero = z;
        cyc = 0; req_idx = 0; waited = 0; done = 0; trapped = 0; retired = 0;
        regwr_cnt = 0; memwr_cnt = 0; memrd_cnt = 0; irwr_cnt = 0; pcwr_cnt = 0;
        overlap = 0; pcsrc_at = -1; m2r_at = -1; regwr_at = -1; trace_len = 0;

        for (int c = 0; c < 40 && done == 0; c++) begin
            if (mem_req) mem_ready = (waited >= ((req_idx == 0) ? fw : mw));
            else         mem_ready = 1'b0;
            #1;
            st_trace[trace_len] = int'(state);
            trace_len++;
            cyc++;
            req_s = mem_req;
            rdy_s = mem_ready;
            if (RegWr)          regwr_cnt++;
            if (MemWr)          memwr_cnt++;
            if (MemRead)        memrd_cnt++;
            if (ir_wr)          irwr_cnt++;
            if (ir_wr && pc_wr) overlap++;
            if (pc_wr) begin
                pcwr_cnt++;
                retired  = 1;
                pcsrc_at = int'(PCSrc);
                m2r_at   = int'(MemtoReg);
                regwr_at = int'(RegWr);
            end
            @(posedge clk); #1;
            if (req_s) begin
                if (rdy_s) begin req_idx++; waited = 0; end
                else       waited++;
            end
            if (retired != 0)         done = 1;
            else if (state == 3'd5) begin done = 1; trapped = 1; end
        end

        chk("bounded", 32'(done), 32'd1);
        chk("trap", 32'(trapped), 32'(e_trap));
        chk("cycles", 32'(cyc), 32'(e_cyc));
        chk("ir_wr_cnt", 32'(irwr_cnt), 32'(e_irwr));
        chk("pc_wr_cnt", 32'(pcwr_cnt), 32'(1 - e_trap));
        chk("regwr_cnt", 32'(regwr_cnt), 32'(e_regwr));
        chk("memwr_cnt", 32'(memwr_cnt), 32'(e_memwr));
        chk("memrd_cnt", 32'(memrd_cnt), 32'(e_memrd));
        chk("irwr_pcwr_overlap", 32'(overlap), 32'd0);
        if (e_trap == 0) begin
            exp_ret++;
            chk("pcsrc_retire", 32'(pcsrc_at), 32'(e_pcsrc));
            chk("memtoreg_retire", 32'(m2r_at), 32'(e_m2r));
            chk("regwr_retire", 32'(regwr_at), 32'(e_regwr));
            chk("back_to_fetch", 32'(state), 32'd0);
        end
        chk("instret", 32'(instret), 32'(exp_ret % 4));
        chk("fault", 32'(fault), 32'(e_trap));
        chk("illegal", 32'(illegal), 32'(e_ill));
        if (e_trap != 0) begin
            for (int h = 0; h < hold; h++) begin
                mem_ready = 1'($urandom_range(0, 1));
                #1;
                chk("trap_strobes", 32'(strobes()), 32'd0);
                chk("trap_state", 32'(state), 32'd5);
                @(posedge clk); #1;
            end
            do_reset();
        end
    endtask

    initial begin
        rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b0;
        legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        do_reset();

        // R-type with zero-wait memory and its state sequence
        run_instr(7'b0110011, 3'd0, 1'b0, 0, 0, 0);
        chk("rtype_seq0", 32'(st_trace[0]), 32'd0);
        chk("rtype_seq1", 32'(st_trace[1]), 32'd1);
        chk("rtype_seq2", 32'(st_trace[2]), 32'd2);
        chk("rtype_seq3", 32'(st_trace[3]), 32'd4);
        // BEQ taken, BNE not taken
        run_instr(7'b1100011, 3'd0, 1'b1, 0, 0, 0);
        run_instr(7'b1100011, 3'd1, 1'b1, 0, 0, 0);
        // LW with three data wait cycles, SW with one
        run_instr(7'b0000011, 3'd2, 1'b0, 0, 3, 0);
        run_instr(7'b0100011, 3'd2, 1'b0, 0, 1, 0);
        // Illegal opcode held in TRAP for 20 cycles, then reset
        run_instr(7'b1111111, 3'd0, 1'b0, 0, 0, 20);
        // Branch with bad funct3 is illegal
        run_instr(7'b1100011, 3'd2, 1'b0, 1, 0, 2);
        // Fetch timeout, then ready exactly on the threshold cycle
        run_instr(7'b0110011, 3'd0, 1'b0, 4, 0, 3);
        run_instr(7'b0110011, 3'd0, 1'b0, 3, 0, 0);
        // Store data timeout
        run_instr(7'b0100011, 3'd2, 1'b0, 0, 4, 2);
        // JAL then JALR
        run_instr(7'b1101111, 3'd0, 1'b0, 0, 0, 0);
        run_instr(7'b1100111, 3'd0, 1'b0, 0, 0, 0);

        // Five retirements on a 2-bit counter wrap to 1
        do_reset();
        run_instr(7'b0110011, 3'd0, 1'b0, 0, 0, 0);
        run_instr(7'b0010011, 3'd0, 1'b0, 1, 0, 0);
        run_instr(7'b0110111, 3'd0, 1'b0, 0, 0, 0);
        run_instr(7'b0010111, 3'd0, 1'b0, 0, 0, 0);
        run_instr(7'b0100011, 3'd2, 1'b0, 0, 2, 0);
        chk("instret_wrap", 32'(instret), 32'd1);

        // Reset while a load waits in MEM abandons it
        opcode = 7'b0000011; funct3 = 3'd2; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst_in_mem", 32'(state), 32'd3);
        do_reset();
        run_instr(7'b0110011, 3'd0, 1'b0, 0, 0, 0);

        // Randomized instructions and memory wait patterns
        for (int i = 0; i < 60; i++) begin
            int r, fw, mw;
            logic [6:0] op;
            r  = int'($urandom_range(0, 10));
            op = (r < 9) ? legal_ops[r] : 7'($urandom_range(0, 127));
            fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 2));
            mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
            run_instr(op, 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), fw, mw, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
